// File: rtl/proyecto1_input_cond_if.sv
// proyecto1_input_cond_if: pin-side lines and timer request/status of the input conditioner
interface proyecto1_input_cond_if #(
   parameter int TMR_W = 8
);
   logic [5:0]       raw_in;
   logic             tmr_start;
   logic [TMR_W-1:0] tmr_len;
   logic             tmr_clr;
   logic [5:0]       clean_out;
   logic [5:0]       rise_out;
   logic             T;
   logic             tmr_busy;
   modport master (output raw_in, tmr_start, tmr_len, tmr_clr, input clean_out, rise_out, T, tmr_busy);
   modport slave (input raw_in, tmr_start, tmr_len, tmr_clr, output clean_out, rise_out, T, tmr_busy);
endinterface

// File: rtl/proyecto1_input_cond.sv
// proyecto1_input_cond: synchronise/debounce six raw lines with rise strobes, plus the T expiry timer
module proyecto1_input_cond #(
   parameter int DB_CYCLES = 4,
   parameter int TMR_W     = 8
) (
   input logic                   clck,
   input logic                   rst,
   proyecto1_input_cond_if.slave bus
);
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} tmr_state_t;
   logic [5:0]       s1, s2, clean, rise, accept;
   tmr_state_t       state;
   logic [TMR_W-1:0] tcnt;
   logic             t_q, busy_q;
   always_ff @(posedge clck or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= bus.raw_in;
         s2 <= s1;
      end
   end
   // each bit counts its own run of disagreement; any agreement restarts it
   for (genvar i = 0; i < 6; i++) begin : g_db
      logic [CW-1:0] cnt;
      assign accept[i] = (s2[i] != clean[i]) && (cnt == CNT_MAX);
      always_ff @(posedge clck or posedge rst) begin
         if (rst) cnt <= '0;
         else cnt <= (s2[i] == clean[i] || accept[i]) ? '0 : cnt + 1'b1;
      end
   end
   always_ff @(posedge clck or posedge rst) begin
      if (rst) begin
         clean <= '0;
         rise  <= '0;
      end else begin
         clean <= clean ^ accept;
         rise  <= accept & ~clean;
      end
   end
   // clr beats start; start reloads from any state, a zero length expires at once
   always_ff @(posedge clck or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         tcnt   <= '0;
         t_q    <= 1'b0;
         busy_q <= 1'b0;
      end else if (bus.tmr_clr) begin
         state  <= IDLE;
         t_q    <= 1'b0;
         busy_q <= 1'b0;
      end else if (bus.tmr_start) begin
         tcnt   <= bus.tmr_len;
         state  <= (bus.tmr_len == '0) ? DONE : RUN;
         t_q    <= bus.tmr_len == '0;
         busy_q <= bus.tmr_len != '0;
      end else if (state == RUN) begin
         tcnt <= tcnt - 1'b1;
         if (tcnt == TMR_W'(1)) begin
            state  <= DONE;
            t_q    <= 1'b1;
            busy_q <= 1'b0;
         end
      end
   end
   assign bus.clean_out = clean;
   assign bus.rise_out  = rise;
   assign bus.T         = t_q;
   assign bus.tmr_busy  = busy_q;
endmodule
